// File: rtl/conv_arbiter.sv
// rtl/conv_arbiter.sv - round-robin arbiter sharing one base-4 converter between two requesters
// Optional WAIT timeout enabled by defining CONV_ARB_TIMEOUT_EN.
module conv_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [1:0]      Req,
    input  logic [4*DW-1:0] Digits0,
    input  logic [4*DW-1:0] Digits1,
    output logic [1:0]      Done,
    output logic [DW-1:0]   Result,
    output logic            Err,
    output logic            Busy,
    output logic            ConvStart,
    output logic [DW-1:0]   ConvX,
    input  logic [DW-1:0]   ConvR,
    input  logic            ConvAck
);

    typedef enum logic [2:0] {IDLE, START, FEED, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic            grant, grant_nx;
    logic            last, last_nx;
    logic [4*DW-1:0] digit_buf, digit_buf_nx;
    logic [1:0]      feed_idx, feed_idx_nx;
    logic [1:0]      done_nx;
    logic [DW-1:0]   result_nx;
    logic            err_nx;
    logic            busy_nx;
    logic            start_nx;
    logic [DW-1:0]   convx_nx;
    logic [4*DW-1:0] sel_digits;

    assign sel_digits = grant ? Digits1 : Digits0;

`ifdef CONV_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic          timed_out;
    assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= IDLE;
            grant     <= 1'b0;
            last      <= 1'b1;
            digit_buf <= '0;
            feed_idx  <= '0;
            Done      <= '0;
            Result    <= '0;
            Err       <= 1'b0;
            Busy      <= 1'b0;
            ConvStart <= 1'b0;
            ConvX     <= '0;
`ifdef CONV_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            last      <= last_nx;
            digit_buf <= digit_buf_nx;
            feed_idx  <= feed_idx_nx;
            Done      <= done_nx;
            Result    <= result_nx;
            Err       <= err_nx;
            Busy      <= busy_nx;
            ConvStart <= start_nx;
            ConvX     <= convx_nx;
`ifdef CONV_ARB_TIMEOUT_EN
            wait_cnt  <= wait_cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        last_nx      = last;
        digit_buf_nx = digit_buf;
        feed_idx_nx  = feed_idx;
        done_nx      = 2'b00;
        result_nx    = Result;
        err_nx       = 1'b0;
        busy_nx      = Busy;
        start_nx     = 1'b0;
        convx_nx     = '0;
`ifdef CONV_ARB_TIMEOUT_EN
        wait_cnt_nx  = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (|Req) begin
                    // last holds the requester served most recently; contention goes to the other one
                    grant_nx = (Req == 2'b11) ? ~last : Req[1];
                    state_nx = START;
                    start_nx = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            START: begin
                // digit 0 goes straight out; the buffer keeps the rest, shifted down
                convx_nx     = sel_digits[DW-1:0];
                digit_buf_nx = sel_digits >> DW;
                feed_idx_nx  = 2'd0;
                state_nx     = FEED;
            end
            FEED: begin
                if (feed_idx == 2'd3) begin
                    state_nx = WAIT;
`ifdef CONV_ARB_TIMEOUT_EN
                    wait_cnt_nx = '0;
`endif
                end else begin
                    convx_nx     = digit_buf[DW-1:0];
                    digit_buf_nx = digit_buf >> DW;
                    feed_idx_nx  = feed_idx + 2'd1;
                end
            end
            WAIT: begin
                if (ConvAck) begin
                    result_nx = ConvR;
                    done_nx   = grant ? 2'b10 : 2'b01;
                    state_nx  = RESP;
`ifdef CONV_ARB_TIMEOUT_EN
                end else if (timed_out) begin
                    result_nx = '0;
                    err_nx    = 1'b1;
                    done_nx   = grant ? 2'b10 : 2'b01;
                    state_nx  = RESP;
                end else begin
                    wait_cnt_nx = wait_cnt + CW'(1);
`endif
                end
            end
            RESP: begin
                last_nx  = grant;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/conv_arbiter.md
# conv_arbiter

Round-robin arbiter and sequencer that shares one base-4-to-binary converter between two requesters. It accepts a request and a packed vector of four digits from each requester. It issues the converter's start pulse, streams the four digits one per cycle, waits for the converter's acknowledge, and returns the result to the granted requester. It sits between the requester blocks and the converter instance.

## Interface
- DW, 8, width of one digit and of the result
- TIMEOUT, 32, maximum WAIT cycles before abort (used only with the timeout feature)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, synchronous, active-low
- Req  in  2  per-requester level request; held with Digits until that requester's Done
- Digits0  in  4*DW  requester 0 digits; digit k at bits [k*DW +: DW]
- Digits1  in  4*DW  requester 1 digits, same packing
- Done  out  2  one-cycle completion pulse, one-hot
- Result  out  DW  conversion result; valid while any Done bit is high
- Err  out  1  high with Done when the transaction timed out
- Busy  out  1  high in every state except IDLE
- ConvStart  out  1  converter start, one-cycle pulse
- ConvX  out  DW  digit stream to the converter
- ConvR  in  DW  converter result
- ConvAck  in  1  converter completion pulse

## Operation
- States: IDLE, START, FEED, WAIT, RESP.
- **IDLE.** If any Req bit is high, select the grant and go to START.
  - Both requesting: grant the requester not served last.
  - After reset, requester 0 has priority.
- **START.** ConvStart=1 for exactly this cycle. Latch the granted Digits vector into an internal 4×DW buffer. Go to FEED.
- **FEED.** Runs 4 cycles. ConvX = buffer digit k in FEED cycle k (k=0..3). Go to WAIT.
- **WAIT.** Hold until ConvAck is sampled high. At that edge, capture ConvR into Result and go to RESP.
- **RESP.** Done[grant]=1 for one cycle. Update the last-served pointer. Go to IDLE.
- ConvX=0 in every state except FEED. Result holds its value until the next capture.
- Digits are latched in START, so changes to Digits after START have no effect on the transaction.
- Req deasserted mid-transaction does not abort the transaction; Done is still pulsed.
- Req still high in the cycle after Done is treated as a new request.
- ConvAck outside WAIT is ignored.
- Reset (Rst_n=0 at an edge) from any state:
  - State goes to IDLE.
  - ConvStart=0, ConvX=0, Done=0, Err=0, Busy=0, Result=0.
  - Last-served pointer is set so requester 0 wins first.
- The converter is not reset by this block.

## Timing
- Req sampled high at edge e → ConvStart high in the cycle after e.
- Digit k is on ConvX during the (k+1)-th cycle after the ConvStart cycle, i.e. the converter samples digit k at edge e+2+k.
- ConvAck sampled high at edge a → Done and Result valid in the cycle after a.
- Busy is already high in the START cycle and stays high through the RESP cycle.
- Minimum spacing between two ConvStart pulses is 8 cycles: START + 4 FEED + ≥1 WAIT + RESP + IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: CONV_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter is cleared on entry to WAIT.
  - If TIMEOUT cycles elapse in WAIT without ConvAck, go to RESP with Err=1 and Result=0, and Done[grant] is pulsed.
  - ConvAck and timeout on the same edge: the acknowledge wins and Err=0.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - Err is tied to 0.
  - The TIMEOUT parameter is unused.

## Test plan
- Single request, no contention:
  - Stimulus: Req=01, Digits0={3,2,1,0}; converter model asserts ConvAck 6 cycles after the last digit with ConvR=8'h1B.
  - Required response: ConvStart is a single pulse; ConvX=0,1,2,3 on consecutive cycles; Done=01 exactly once; Result=8'h1B; Err=0.
- Contention with round-robin:
  - Stimulus: Req=11 held continuously.
  - Required response: grants alternate 0,1,0,1 over four transactions; Done is never 11.
- Reset during FEED:
  - Stimulus: Rst_n=0 for one edge after digit 1 has been streamed.
  - Required response: next cycle all outputs are 0 and state is IDLE; a subsequent Req=10 completes normally with Done=10.
- Inputs changing mid-transaction:
  - Stimulus: Digits0 changed and Req dropped after START.
  - Required response: ConvX streams the original latched digits; Done=01 is still pulsed.
- Stray acknowledge:
  - Stimulus: ConvAck pulse while in IDLE, then while in FEED.
  - Required response: no Done; Result unchanged.
- Timeout (CONV_ARB_TIMEOUT_EN, TIMEOUT=32):
  - Stimulus: ConvAck never asserted.
  - Required response: Done and Err high together exactly 32 cycles after WAIT entry; Result=0.
  - Repeat with ConvAck on the 32nd WAIT edge: Err=0.
